alu_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational 64-bit ALU used in the EX stage.
- Width generalised; LSL/LSR added in the spare cntrl codes.
- Computes in a LATENCY-deep valid/ready pipeline and holds architectural NZVC flags in a register.
- Flags update only for flag-setting ops (ADDS/SUBS-style) when the result is consumed.
- Sits between the ID/EX register and the EX/MEM register; lets the CPU take backpressure from a stalled MEM stage.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 74 +++++++
 rtl/alu_pipe.sv | 104 ++++++++++
 tb/tb_alu_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined EX-stage ALU.
//   alu_op_e    - 3-bit operation code carried on cntrl
//   alu_flags_t - packed {n, z, v, c} flag bundle
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_LSL      = 3'b001,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110,
    ALU_LSR      = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '{n: 1'b0, z: 1'b0, v: 1'b0, c: 1'b0};

  // True for the ops that drive the adder's carry/overflow outputs.
  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUBTRACT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   a, b    - WIDTH-bit operands; b[S-1:0] is the shift amount for LSL/LSR
//   op      - operation code
//   result  - WIDTH-bit result
//   flags   - per-op {n, z, v, c}; v/c are only non-zero for ADD/SUB
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int S = $clog2(WIDTH);

  logic [S-1:0]     shamt;
  logic [WIDTH-1:0] b_add;
  logic             carry_in;
  logic [WIDTH:0]   sum;

  assign shamt = b[S-1:0];

  // SUB is computed as A + ~B + 1 so that carry=1 means "no borrow".
  always_comb begin
    b_add    = b;
    carry_in = 1'b0;
    if (op == ALU_SUBTRACT) begin
      b_add    = ~b;
      carry_in = 1'b1;
    end else begin
      b_add    = b;
      carry_in = 1'b0;
    end
  end

  assign sum = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, carry_in};

  // Result select.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      ALU_PASS_B:   result = b;
      ALU_LSL:      result = a << shamt;
      ALU_ADD:      result = sum[WIDTH-1:0];
      ALU_SUBTRACT: result = sum[WIDTH-1:0];
      ALU_AND:      result = a & b;
      ALU_OR:       result = a | b;
      ALU_XOR:      result = a ^ b;
      ALU_LSR:      result = a >> shamt;
      default:      result = b;
    endcase
  end

  // Per-op flags; overflow uses the equivalent "same-sign inputs, different-sign
  // sum" form of carry-into-MSB XOR carry-out-of-MSB.
  always_comb begin
    flags   = FLAGS_CLEAR;
    flags.n = result[WIDTH-1];
    flags.z = (result == {WIDTH{1'b0}});
    if (is_arith(op)) begin
      flags.c = sum[WIDTH];
      flags.v = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      flags.c = 1'b0;
      flags.v = 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: LATENCY-deep valid/ready pipelined ALU with an architectural NZVC
// flag register.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   in_valid/in_ready           - input handshake (A, B, cntrl, set_flags)
//   out_valid/out_ready         - output handshake (result + per-op flags)
//   negative/zero/overflow/carry_out - flags travelling with result
//   flag_n/z/v/c                - flag register, updated when a set_flags op retires
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c
);

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  logic [WIDTH-1:0] st_result [LATENCY];
  alu_flags_t       st_flags  [LATENCY];
  logic [LATENCY-1:0] st_valid;
  logic [LATENCY-1:0] st_set;
  alu_flags_t       flag_reg;
  logic             stall;
  logic             retire;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (B),
    .op     (alu_op_e'(cntrl)),
    .result (core_result),
    .flags  (core_flags)
  );

  // Whole-pipe stall: nothing moves while the head result is not taken.
  assign stall    = st_valid[LATENCY-1] & ~out_ready;
  assign in_ready = ~stall;
  assign retire   = st_valid[LATENCY-1] & out_ready;

  // Control state: stage valid/set_flags bits and the flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_valid <= {LATENCY{1'b0}};
      st_set   <= {LATENCY{1'b0}};
      flag_reg <= FLAGS_CLEAR;
    end else begin
      if (!stall) begin
        st_valid[0] <= in_valid;
        st_set[0]   <= set_flags;
        for (int i = 1; i < LATENCY; i++) begin
          st_valid[i] <= st_valid[i-1];
          st_set[i]   <= st_set[i-1];
        end
      end
      if (retire && st_set[LATENCY-1]) begin
        flag_reg <= st_flags[LATENCY-1];
      end
    end
  end

  // Datapath stages; contents are don't-care while the matching valid is low.
  always_ff @(posedge clk) begin
    if (!stall) begin
      st_result[0] <= core_result;
      st_flags[0]  <= core_flags;
      for (int i = 1; i < LATENCY; i++) begin
        st_result[i] <= st_result[i-1];
        st_flags[i]  <= st_flags[i-1];
      end
    end
  end

  assign out_valid = st_valid[LATENCY-1];
  assign result    = st_result[LATENCY-1];
  assign negative  = st_flags[LATENCY-1].n;
  assign zero      = st_flags[LATENCY-1].z;
  assign overflow  = st_flags[LATENCY-1].v;
  assign carry_out = st_flags[LATENCY-1].c;
  assign flag_n    = flag_reg.n;
  assign flag_z    = flag_reg.z;
  assign flag_v    = flag_reg.v;
  assign flag_c    = flag_reg.c;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe. Two instances share a clock:
// dut0 is WIDTH=64/LATENCY=2, dut1 is WIDTH=16/LATENCY=1. An arithmetic
// reference model feeds per-instance scoreboards; directed steps cover the
// spec examples, stalls and mid-flight reset.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  nzvc;
    logic        sf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        iv0, ir0, sf0, ov0, rdy0, n0, z0, v0, c0, fn0, fz0, fv0, fc0;
  logic [63:0] a0, b0, r0;
  logic [2:0]  op0;
  logic        iv1, ir1, sf1, ov1, rdy1, n1, z1, v1, c1, fn1, fz1, fv1, fc1;
  logic [15:0] a1, b1, r1;
  logic [2:0]  op1;

  alu_pipe #(.WIDTH(64), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .cntrl(op0), .set_flags(sf0), .out_valid(ov0), .out_ready(rdy0), .result(r0),
    .negative(n0), .zero(z0), .overflow(v0), .carry_out(c0),
    .flag_n(fn0), .flag_z(fz0), .flag_v(fv0), .flag_c(fc0)
  );

  alu_pipe #(.WIDTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .cntrl(op1), .set_flags(sf1), .out_valid(ov1), .out_ready(rdy1), .result(r1),
    .negative(n1), .zero(z1), .overflow(v1), .carry_out(c1),
    .flag_n(fn1), .flag_z(fz1), .flag_v(fv1), .flag_c(fc1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] ret0[$];
  logic [3:0]  mf [2];
  logic        was_stall [2];
  logic [63:0] held_res [2];
  logic [3:0]  held_pf [2];
  int          acc [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from the true signed value.
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b, input logic sf);
    logic [127:0] one, pw, mask, ua, ub, full;
    logic signed [127:0] sa, sb, ssum, smax, smin;
    int amt;
    logic v, c;
    exp_t e;
    one  = 128'd1;
    pw   = one << w;
    mask = pw - one;
    ua   = {64'd0, a} & mask;
    ub   = {64'd0, b} & mask;
    sa   = ua[w-1] ? $signed(ua - pw) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub - pw) : $signed(ub);
    smax = $signed((one << (w-1)) - one);
    smin = $signed(-(one << (w-1)));
    amt  = int'(ub[7:0]) % w;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: full = ub;
      3'd1: full = ua << amt;
      3'd2: begin
        full = ua + ub;
        c    = (full >= pw);
        ssum = sa + sb;
        v    = (ssum > smax) || (ssum < smin);
      end
      3'd3: begin
        full = ua - ub;
        c    = (ua >= ub);
        ssum = sa - sb;
        v    = (ssum > smax) || (ssum < smin);
      end
      3'd4: full = ua & ub;
      3'd5: full = ua | ub;
      3'd6: full = ua ^ ub;
      default: full = ua >> amt;
    endcase
    full   = full & mask;
    e.res  = full[63:0];
    e.nzvc = {full[w-1], full == 128'd0, v, c};
    e.sf   = sf;
    return e;
  endfunction

  task automatic drive(input int d, input logic iv, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic sf);
    if (d == 0) begin
      iv0 = iv; op0 = op; a0 = a; b0 = b; sf0 = sf;
    end else begin
      iv1 = iv; op1 = op; a1 = a[15:0]; b1 = b[15:0]; sf1 = sf;
    end
  endtask

  function automatic logic        ov_of(input int d);  return (d == 0) ? ov0 : ov1; endfunction
  function automatic logic [63:0] res_of(input int d); return (d == 0) ? r0 : {48'd0, r1}; endfunction
  function automatic logic [3:0]  pf_of(input int d);  return (d == 0) ? {n0, z0, v0, c0} : {n1, z1, v1, c1}; endfunction
  function automatic logic [3:0]  fr_of(input int d);  return (d == 0) ? {fn0, fz0, fv0, fc0} : {fn1, fz1, fv1, fc1}; endfunction

  // Handshake bookkeeping just before an edge.
  task automatic pre(input int d, input logic ov, input logic rdy, input logic ir, input logic iv,
                     input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic sf);
    exp_t e;
    logic nonempty;
    chk($sformatf("in_ready%0d", d), 64'(ir), 64'(!(ov && !rdy)));
    was_stall[d] = ov && !rdy;
    held_res[d]  = res_of(d);
    held_pf[d]   = pf_of(d);
    if (ov && rdy) begin
      nonempty = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      chk($sformatf("retire_expected%0d", d), 64'(nonempty), 64'd1);
      if (nonempty) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("result%0d", d), res_of(d), e.res);
        chk($sformatf("opflags%0d", d), 64'(pf_of(d)), 64'(e.nzvc));
        if (e.sf) mf[d] = e.nzvc;
        if (d == 0) ret0.push_back(res_of(d));
      end
    end
    if (iv && ir) begin
      acc[d]++;
      if (d == 0) q0.push_back(model(64, op, a, b, sf));
      else        q1.push_back(model(16, op, a, b, sf));
    end
  endtask

  task automatic post(input int d);
    chk($sformatf("flagreg%0d", d), 64'(fr_of(d)), 64'(mf[d]));
    if (was_stall[d]) begin
      chk($sformatf("hold_valid%0d", d), 64'(ov_of(d)), 64'd1);
      chk($sformatf("hold_result%0d", d), res_of(d), held_res[d]);
      chk($sformatf("hold_flags%0d", d), 64'(pf_of(d)), 64'(held_pf[d]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    pre(0, ov0, rdy0, ir0, iv0, op0, a0, b0, sf0);
    pre(1, ov1, rdy1, ir1, iv1, op1, {48'd0, a1}, {48'd0, b1}, sf1);
    @(posedge clk);
    #1;
    post(0);
    post(1);
  endtask

  task automatic run_one(input int d, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic sf, input logic [63:0] xr, input logic [3:0] xf, input logic [3:0] xreg);
    int lat;
    lat = (d == 0) ? 2 : 1;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    drive(d, 1'b1, op, a, b, sf);
    step();
    drive(d, 1'b0, op, a, b, sf);
    for (int k = 1; k < lat; k++) begin
      chk("early_valid", 64'(ov_of(d)), 64'd0);
      step();
    end
    chk("latency_valid", 64'(ov_of(d)), 64'd1);
    chk("dir_result", res_of(d), xr);
    chk("dir_opflags", 64'(pf_of(d)), 64'(xf));
    step();
    chk("dir_flagreg", 64'(fr_of(d)), 64'(xreg));
  endtask

  initial begin
    int i;
    int base;
    mf[0] = 4'd0; mf[1] = 4'd0;
    was_stall[0] = 1'b0; was_stall[1] = 1'b0;
    acc[0] = 0; acc[1] = 0;
    reset = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1;
    drive(0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_valid0", 64'(ov0), 64'd0);
    chk("reset_ready0", 64'(ir0), 64'd1);
    chk("reset_flags0", 64'({fn0, fz0, fv0, fc0}), 64'd0);
    chk("reset_valid1", 64'(ov1), 64'd0);
    chk("reset_flags1", 64'({fn1, fz1, fv1, fc1}), 64'd0);

    // Directed examples on the 64-bit, 2-stage instance.
    run_one(0, ALU_ADD, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 4'b0101, 4'b0101);
    run_one(0, ALU_SUBTRACT, 64'd2, 64'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b0101);
    run_one(0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 4'b1010, 4'b1010);
    run_one(0, ALU_LSL, 64'd1, 64'd63, 1'b0, 64'h8000_0000_0000_0000, 4'b1000, 4'b1010);
    run_one(0, ALU_LSR, 64'hDEAD_BEEF_0123_4567, 64'd64, 1'b1, 64'hDEAD_BEEF_0123_4567, 4'b1000, 4'b1000);
    // 16-bit, single-stage instance.
    run_one(1, ALU_AND, 64'hF0F0, 64'h0FF0, 1'b0, 64'h00F0, 4'b0000, 4'b0000);

    // Back-to-back ADDs i+i with the consumer stalling on cycles 3..5.
    ret0.delete();
    base = acc[0];
    for (int c = 1; c <= 30; c++) begin
      i = acc[0] - base + 1;
      if (i > 5 && q0.size() == 0 && !ov0) break;
      rdy0 = !(c >= 3 && c <= 5);
      drive(0, i <= 5, ALU_ADD, 64'(i), 64'(i), 1'b0);
      step();
    end
    rdy0 = 1'b1;
    drive(0, 1'b0, ALU_ADD, 64'd0, 64'd0, 1'b0);
    chk("b2b_count", 64'(ret0.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < ret0.size()) chk($sformatf("b2b_order%0d", k), ret0[k], 64'(2 * (k + 1)));
    end

    // Reset with two flag-setting ops in flight.
    drive(0, 1'b1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step();
    step();
    drive(0, 1'b0, ALU_ADD, 64'd0, 64'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    mf[0] = 4'd0; mf[1] = 4'd0;
    was_stall[0] = 1'b0; was_stall[1] = 1'b0;
    chk("midrst_valid", 64'(ov0), 64'd0);
    chk("midrst_ready", 64'(ir0), 64'd1);
    chk("midrst_flags", 64'({fn0, fz0, fv0, fc0}), 64'd0);
    step();
    chk("midrst_noretire", 64'(ov0), 64'd0);
    run_one(0, ALU_ADD, 64'd40, 64'd2, 1'b1, 64'd42, 4'b0000, 4'b0000);

    // Random traffic on both instances with random backpressure; dut1 cycles
    // through all opcodes so each sees at least 100 ops.
    base = acc[1];
    for (int c = 0; c < 4000 && (acc[1] - base) < 800; c++) begin
      drive(0, 1'(($urandom % 4) != 0), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      drive(1, 1'(($urandom % 8) != 0), 3'((acc[1] - base) % 8), 64'($urandom), 64'($urandom), 1'($urandom));
      rdy0 = 1'(($urandom % 4) != 0);
      rdy1 = 1'(($urandom % 4) != 0);
      step();
    end
    chk("rand_accepts1", 64'((acc[1] - base) >= 800), 64'd1);
    drive(0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
